kbd_box_sched: RTL and testbench

Keyboard command scheduler between the PS/2 receiver and the VGA pixel datapath. Decodes the receiver's scancode stream, including the E0 and F0 prefixes, into movement and colour commands. Queues the commands in a small FIFO and applies at most one per video frame, at the frame-start strobe, to the registered box position and colour consumed by the VGA/extra drawing logic. This keeps keyboard updates tear-free and rate-limited to the frame rate.

---
 rtl/kbd_box_sched.sv | 157 +++++++++++++++
 tb/tb_kbd_box_sched.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kbd_box_sched.sv
// kbd_box_sched: PS/2 scancode decoder feeding a command FIFO.
// It applies at most one command per frame to the box position and colour.
// Ports:
//   clk, reset (async active-low)
//   scancode/flagkey: bytes from the PS/2 receiver
//   frame_start: pops and applies one queued command
//   box_x/box_y/box_rgb: registered box state
//   queue_level/overflow: FIFO status
module kbd_box_sched #(
  parameter int HRES  = 640,
  parameter int VRES  = 480,
  parameter int BOX   = 32,
  parameter int STEP  = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       flagkey,
  input  logic       frame_start,
  output logic [9:0] box_x,
  output logic [8:0] box_y,
  output logic [8:0] box_rgb,
  output logic [2:0] queue_level,
  output logic       overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int XMAX = HRES - BOX;
  localparam int YMAX = VRES - BOX;
  localparam logic [9:0] XHOME = 10'((HRES - BOX) / 2);
  localparam logic [8:0] YHOME = 9'((VRES - BOX) / 2);

  typedef enum logic [1:0] {
    IDLE, EXT, BRK, EXT_BRK
  } state_t;

  typedef enum logic [2:0] {
    C_UP, C_DOWN, C_LEFT, C_RIGHT,
    C_RED, C_GRN, C_BLU, C_HOME
  } cmd_t;

  state_t state, state_nx;
  logic   push;
  cmd_t   push_cmd;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    push_cmd = C_HOME;
    if (flagkey) begin
      case (state)
        IDLE: begin
          case (scancode)
            8'hE0: state_nx = EXT;
            8'hF0: state_nx = BRK;
            8'h2D: begin push = 1'b1; push_cmd = C_RED;  end
            8'h34: begin push = 1'b1; push_cmd = C_GRN;  end
            8'h32: begin push = 1'b1; push_cmd = C_BLU;  end
            8'h29: begin push = 1'b1; push_cmd = C_HOME; end
            default: state_nx = IDLE;
          endcase
        end
        EXT: begin
          state_nx = IDLE;
          case (scancode)
            8'h75: begin push = 1'b1; push_cmd = C_UP;    end
            8'h72: begin push = 1'b1; push_cmd = C_DOWN;  end
            8'h6B: begin push = 1'b1; push_cmd = C_LEFT;  end
            8'h74: begin push = 1'b1; push_cmd = C_RIGHT; end
            8'hF0: state_nx = EXT_BRK;
            default: state_nx = IDLE;
          endcase
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, pop, wr_en;
  cmd_t          head;

  assign full  = queue_level == 3'(DEPTH);
  assign empty = queue_level == 3'd0;
  assign pop   = frame_start && !empty;
  // a simultaneous pop frees a slot, so a push into a full FIFO still lands
  assign wr_en = push && (!full || pop);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_cmd;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_level <= '0;
      overflow    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   queue_level <= queue_level + 3'd1;
        2'b01:   queue_level <= queue_level - 3'd1;
        default: queue_level <= queue_level;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  // one extra bit: the MSB flags a subtraction that went below zero
  logic [10:0] x_dec, x_inc;
  logic [9:0]  y_dec, y_inc;
  logic [9:0]  x_left, x_right;
  logic [8:0]  y_up, y_down;

  assign x_dec   = {1'b0, box_x} - 11'(STEP);
  assign x_inc   = {1'b0, box_x} + 11'(STEP);
  assign y_dec   = {1'b0, box_y} - 10'(STEP);
  assign y_inc   = {1'b0, box_y} + 10'(STEP);
  assign x_left  = x_dec[10] ? 10'd0 : x_dec[9:0];
  assign x_right = (x_inc > 11'(XMAX)) ? 10'(XMAX) : x_inc[9:0];
  assign y_up    = y_dec[9] ? 9'd0 : y_dec[8:0];
  assign y_down  = (y_inc > 10'(YMAX)) ? 9'(YMAX) : y_inc[8:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      box_x   <= XHOME;
      box_y   <= YHOME;
      box_rgb <= 9'h1FF;
    end else if (pop) begin
      unique case (head)
        C_UP:    box_y <= y_up;
        C_DOWN:  box_y <= y_down;
        C_LEFT:  box_x <= x_left;
        C_RIGHT: box_x <= x_right;
        C_RED:   box_rgb[8:6] <= box_rgb[8:6] + 3'd1;
        C_GRN:   box_rgb[5:3] <= box_rgb[5:3] + 3'd1;
        C_BLU:   box_rgb[2:0] <= box_rgb[2:0] + 3'd1;
        C_HOME: begin
          box_x   <= XHOME;
          box_y   <= YHOME;
          box_rgb <= 9'h1FF;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kbd_box_sched.sv
// tb_kbd_box_sched: directed bench for kbd_box_sched.
// Drives scancodes and frame pulses on the falling edge and checks there.
module tb_kbd_box_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic       flagkey = 1'b0;
  logic       frame_start = 1'b0;
  logic [9:0] box_x;
  logic [8:0] box_y;
  logic [8:0] box_rgb;
  logic [2:0] queue_level;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  kbd_box_sched dut (
    .clk(clk), .reset(reset),
    .scancode(scancode), .flagkey(flagkey),
    .frame_start(frame_start),
    .box_x(box_x), .box_y(box_y),
    .box_rgb(box_rgb),
    .queue_level(queue_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    flagkey = 1'b0;
    frame_start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scancode = b;
    flagkey = 1'b1;
    @(negedge clk);
    flagkey = 1'b0;
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (box_x !== 10'd304) begin
      $display("FAIL reset_x got %0d want 304", box_x); errors++;
    end
    if (box_y !== 9'd224) begin
      $display("FAIL reset_y got %0d want 224", box_y); errors++;
    end
    if (box_rgb !== 9'h1FF) begin
      $display("FAIL reset_rgb got %h want 1ff", box_rgb); errors++;
    end
    if (queue_level !== 3'd0) begin
      $display("FAIL reset_lvl got %0d want 0", queue_level); errors++;
    end
    if (overflow !== 1'b0) begin
      $display("FAIL reset_ovf got %b want 0", overflow); errors++;
    end
  endtask

  task automatic test_right();
    do_reset();
    send(8'hE0);
    send(8'h74);
    checks += 2;
    if (queue_level !== 3'd1) begin
      $display("FAIL right_lvl got %0d want 1", queue_level); errors++;
    end
    if (box_x !== 10'd304) begin
      $display("FAIL right_early got %0d want 304", box_x); errors++;
    end
    frame();
    checks += 3;
    if (box_x !== 10'd312) begin
      $display("FAIL right_x got %0d want 312", box_x); errors++;
    end
    if (box_y !== 9'd224) begin
      $display("FAIL right_y got %0d want 224", box_y); errors++;
    end
    if (queue_level !== 3'd0) begin
      $display("FAIL right_lvl0 got %0d want 0", queue_level); errors++;
    end
  endtask

  task automatic test_clamp();
    int ex;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      send(8'hE0);
      send(8'h6B);
      frame();
      ex = (8 * i <= 304) ? 304 - 8 * i : 0;
      checks++;
      if (box_x !== 10'(ex)) begin
        $display("FAIL left_%0d got %0d want %0d", i, box_x, ex);
        errors++;
      end
    end
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      send(8'hE0);
      send(8'h72);
      frame();
      ex = (224 + 8 * i >= 448) ? 448 : 224 + 8 * i;
      checks++;
      if (box_y !== 9'(ex)) begin
        $display("FAIL down_%0d got %0d want %0d", i, box_y, ex);
        errors++;
      end
    end
  endtask

  task automatic test_color();
    logic [2:0] r;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send(8'h2D);
      frame();
      r = 3'(7 + i);
      checks++;
      if (box_rgb !== {r, 6'o77}) begin
        $display("FAIL red_%0d got %h want %h", i, box_rgb, {r, 6'o77});
        errors++;
      end
    end
    send(8'h34);
    frame();
    send(8'hE0);
    send(8'h75);
    frame();
    checks += 2;
    if (box_rgb !== 9'h1C7) begin
      $display("FAIL grn_wrap got %h want 1c7", box_rgb); errors++;
    end
    if (box_y !== 9'd216) begin
      $display("FAIL up_y got %0d want 216", box_y); errors++;
    end
    send(8'h29);
    frame();
    checks += 3;
    if (box_x !== 10'd304 || box_y !== 9'd224) begin
      $display("FAIL home_xy got %0d/%0d want 304/224", box_x, box_y);
      errors++;
    end
    if (box_rgb !== 9'h1FF) begin
      $display("FAIL home_rgb got %h want 1ff", box_rgb); errors++;
    end
    if (queue_level !== 3'd0) begin
      $display("FAIL home_lvl got %0d want 0", queue_level); errors++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send(8'hE0); send(8'h75);
    send(8'h32);
    send(8'hE0); send(8'h6B);
    send(8'h34);
    checks += 2;
    if (queue_level !== 3'd4) begin
      $display("FAIL full_lvl got %0d want 4", queue_level); errors++;
    end
    if (overflow !== 1'b0) begin
      $display("FAIL full_ovf got %b want 0", overflow); errors++;
    end
    send(8'h2D);
    checks += 2;
    if (queue_level !== 3'd4) begin
      $display("FAIL ovf_lvl got %0d want 4", queue_level); errors++;
    end
    if (overflow !== 1'b1) begin
      $display("FAIL ovf_set got %b want 1", overflow); errors++;
    end
    send(8'h2D);
    frame();
    checks++;
    if (box_y !== 9'd216) begin
      $display("FAIL ovf_up got %0d want 216", box_y); errors++;
    end
    frame();
    checks++;
    if (box_rgb !== 9'h1F8) begin
      $display("FAIL ovf_blu got %h want 1f8", box_rgb); errors++;
    end
    frame();
    checks++;
    if (box_x !== 10'd296) begin
      $display("FAIL ovf_left got %0d want 296", box_x); errors++;
    end
    frame();
    checks += 2;
    if (box_rgb !== 9'h1C0) begin
      $display("FAIL ovf_grn got %h want 1c0", box_rgb); errors++;
    end
    if (queue_level !== 3'd0) begin
      $display("FAIL ovf_empty got %0d want 0", queue_level); errors++;
    end
    frame();
    checks += 2;
    if (box_rgb !== 9'h1C0 || box_x !== 10'd296) begin
      $display("FAIL empty_frame got %h/%0d want 1c0/296",
               box_rgb, box_x);
      errors++;
    end
    if (overflow !== 1'b1) begin
      $display("FAIL ovf_sticky got %b want 1", overflow); errors++;
    end
  endtask

  task automatic test_break();
    do_reset();
    send(8'hF0); send(8'h74);
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0); send(8'h12);
    checks++;
    if (queue_level !== 3'd0) begin
      $display("FAIL brk_lvl got %0d want 0", queue_level); errors++;
    end
    send(8'h34);
    checks++;
    if (queue_level !== 3'd1) begin
      $display("FAIL brk_push got %0d want 1", queue_level); errors++;
    end
    frame();
    checks += 2;
    if (box_rgb !== 9'h1C7) begin
      $display("FAIL brk_grn got %h want 1c7", box_rgb); errors++;
    end
    if (box_x !== 10'd304) begin
      $display("FAIL brk_x got %0d want 304", box_x); errors++;
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (4) send(8'h2D);
    @(negedge clk);
    scancode = 8'h34;
    flagkey = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    flagkey = 1'b0;
    frame_start = 1'b0;
    checks += 3;
    if (queue_level !== 3'd4) begin
      $display("FAIL b2b_lvl got %0d want 4", queue_level); errors++;
    end
    if (overflow !== 1'b0) begin
      $display("FAIL b2b_ovf got %b want 0", overflow); errors++;
    end
    if (box_rgb !== 9'h03F) begin
      $display("FAIL b2b_rgb got %h want 03f", box_rgb); errors++;
    end
    repeat (4) frame();
    checks++;
    if (box_rgb !== 9'h0C7) begin
      $display("FAIL b2b_drain got %h want 0c7", box_rgb); errors++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'hE0); send(8'h74);
    frame();
    repeat (5) send(8'h2D);
    send(8'hE0);
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (box_x !== 10'd304) begin
      $display("FAIL mid_x got %0d want 304", box_x); errors++;
    end
    if (box_rgb !== 9'h1FF) begin
      $display("FAIL mid_rgb got %h want 1ff", box_rgb); errors++;
    end
    if (queue_level !== 3'd0) begin
      $display("FAIL mid_lvl got %0d want 0", queue_level); errors++;
    end
    if (overflow !== 1'b0) begin
      $display("FAIL mid_ovf got %b want 0", overflow); errors++;
    end
    @(negedge clk);
    reset = 1'b1;
    send(8'h74);
    checks++;
    if (queue_level !== 3'd0) begin
      $display("FAIL mid_prefix got %0d want 0", queue_level); errors++;
    end
    send(8'h2D);
    checks++;
    if (queue_level !== 3'd1) begin
      $display("FAIL mid_push got %0d want 1", queue_level); errors++;
    end
  endtask

  initial begin
    test_reset();
    test_right();
    test_clamp();
    test_color();
    test_overflow();
    test_break();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
